// File: rtl/id_pkg.sv
// Shared decode constants, sequencer state type and condition check for the ID stage.
package id_pkg;

    // ALU command encodings driven on exe_cmd
    localparam logic [3:0] EXE_NOP  = 4'b0000;
    localparam logic [3:0] EXE_MOV  = 4'b0001;
    localparam logic [3:0] EXE_ADD  = 4'b0010;
    localparam logic [3:0] EXE_ADC  = 4'b0011;
    localparam logic [3:0] EXE_SUB  = 4'b0100;
    localparam logic [3:0] EXE_SBC  = 4'b0101;
    localparam logic [3:0] EXE_AND  = 4'b0110;
    localparam logic [3:0] EXE_ORR  = 4'b0111;
    localparam logic [3:0] EXE_EOR  = 4'b1000;
    localparam logic [3:0] EXE_MVN  = 4'b1001;
    localparam logic [3:0] EXE_MC   = 4'b1010;
    localparam logic [3:0] EXE_LDST = 4'b0010;

    // Instruction class in instr[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Data-processing opcodes in instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Condition codes in instr[31:28]
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;

    localparam logic [3:0] MC_OPCODE_DEFAULT = 4'b0011;

    // Sequencer state encodings kept as fixed constants for legacy compatibility
    localparam logic [0:0] ST_IDLE_ENC = 1'b0;
    localparam logic [0:0] ST_MC_ENC   = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_MC   = ST_MC_ENC
    } id_state_e;

    // sr is {N,Z,C,V}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] sr);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = sr;
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = ~z;
            CC_CS:   pass = c;
            CC_CC:   pass = ~c;
            CC_MI:   pass = n;
            CC_PL:   pass = ~n;
            CC_VS:   pass = v;
            CC_VC:   pass = ~v;
            CC_HI:   pass = c & ~z;
            CC_LS:   pass = ~c | z;
            CC_GE:   pass = (n == v);
            CC_LT:   pass = (n != v);
            CC_GT:   pass = ~z & (n == v);
            CC_LE:   pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 16-entry register file: synchronous write, write-through combinational reads.
module id_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        raddr1,
    input  logic [3:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [16];

    // Clear on reset, otherwise capture write-back data
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Bypass the in-flight write so a same-cycle read sees the new value
    always_comb begin
        rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
        rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/id_stage_mc.sv
// Instruction decode stage with register file, condition check and multi-cycle sequencer.
module id_stage_mc
    import id_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         MC_CYCLES = 2,
    parameter logic [3:0] MC_OPCODE = MC_OPCODE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] result_wb,
    input  logic              wb_en_in,
    input  logic [3:0]        dest_wb,
    input  logic [3:0]        sr,
    input  logic              hazard,
    input  logic              flush,
    output logic              stall_if,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic              mc_last
);

    localparam int unsigned PH_W = $clog2(MC_CYCLES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(MC_CYCLES - 1);

    logic [1:0] mode;
    logic [3:0] opcode;
    logic [3:0] rn, rd, rm;
    logic       is_store, cond_pass, bubble, is_mc_op;

    logic       dec_wb, dec_mr, dec_mw, dec_b, dec_s;
    logic [3:0] dec_cmd;

    id_state_e       state, state_n;
    logic [PH_W-1:0] ph, ph_n;
    logic            final_issue;

    logic [DATA_W-1:0] rdata1, rdata2;

    assign mode   = instr[27:26];
    assign opcode = instr[24:21];
    assign rn     = instr[19:16];
    assign rd     = instr[15:12];
    assign rm     = instr[3:0];

    assign is_store  = (mode == MODE_MEM) && !instr[20];
    assign src1      = rn;
    assign src2      = is_store ? rd : rm;
    assign two_src   = is_store | ~instr[25];
    assign cond_pass = cond_check(instr[31:28], sr);
    assign bubble    = hazard | flush | ~instr_valid | ~cond_pass;
    assign is_mc_op  = instr_valid && (mode == MODE_DP) && (opcode == MC_OPCODE);

    id_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en_in),
        .waddr  (dest_wb),
        .wdata  (result_wb),
        .raddr1 (src1),
        .raddr2 (src2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // Control decode from instruction class and opcode
    always_comb begin
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_cmd = EXE_NOP;
        case (mode)
            MODE_DP: begin
                dec_s = instr[20];
                if (opcode == MC_OPCODE) begin
                    dec_cmd = EXE_MC;
                    dec_wb  = 1'b1;
                end else begin
                    case (opcode)
                        OP_MOV: begin dec_cmd = EXE_MOV; dec_wb = 1'b1; end
                        OP_MVN: begin dec_cmd = EXE_MVN; dec_wb = 1'b1; end
                        OP_ADD: begin dec_cmd = EXE_ADD; dec_wb = 1'b1; end
                        OP_ADC: begin dec_cmd = EXE_ADC; dec_wb = 1'b1; end
                        OP_SUB: begin dec_cmd = EXE_SUB; dec_wb = 1'b1; end
                        OP_SBC: begin dec_cmd = EXE_SBC; dec_wb = 1'b1; end
                        OP_AND: begin dec_cmd = EXE_AND; dec_wb = 1'b1; end
                        OP_ORR: begin dec_cmd = EXE_ORR; dec_wb = 1'b1; end
                        OP_EOR: begin dec_cmd = EXE_EOR; dec_wb = 1'b1; end
                        OP_CMP: dec_cmd = EXE_SUB;
                        OP_TST: dec_cmd = EXE_AND;
                        default: ;
                    endcase
                end
            end
            MODE_MEM: begin
                dec_cmd = EXE_LDST;
                if (instr[20]) begin
                    dec_mr = 1'b1;
                    dec_wb = 1'b1;
                end else begin
                    dec_mw = 1'b1;
                end
            end
            MODE_BR: dec_b = 1'b1;
            default: ;
        endcase
    end

    // Sequencer next state, phase and fetch stall
    always_comb begin
        state_n     = state;
        ph_n        = ph;
        stall_if    = 1'b0;
        final_issue = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_mc_op && !bubble) begin
                    stall_if = 1'b1;
                    state_n  = ST_MC;
                    ph_n     = PH_W'(1);
                end
            end
            ST_MC: begin
                if (flush) begin
                    state_n = ST_IDLE;
                    ph_n    = '0;
                end else if (hazard) begin
                    stall_if = 1'b1;
                end else if (ph == PH_LAST) begin
                    // Condition failure still consumes the phase; only hazard holds it
                    final_issue = 1'b1;
                    state_n     = ST_IDLE;
                    ph_n        = '0;
                end else begin
                    stall_if = 1'b1;
                    ph_n     = ph + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                ph_n    = '0;
            end
        endcase
    end

    // ID/EX register and sequencer state update
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            ph            <= '0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            exe_cmd       <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            mc_last       <= 1'b0;
        end else begin
            state         <= state_n;
            ph            <= ph_n;
            wb_en         <= dec_wb & ~bubble;
            mem_r_en      <= dec_mr & ~bubble;
            mem_w_en      <= dec_mw & ~bubble;
            b             <= dec_b & ~bubble;
            s             <= dec_s & ~bubble;
            exe_cmd       <= bubble ? EXE_NOP : dec_cmd;
            mc_last       <= final_issue & ~bubble;
            val_rn        <= rdata1;
            val_rm        <= rdata2;
            imm           <= instr[25];
            shift_operand <= instr[11:0];
            signed_imm_24 <= instr[23:0];
            dest          <= final_issue ? rn : rd;
        end
    end

endmodule

// File: tb/tb_id_stage_mc.sv
// Scoreboard bench: two decode stages (2- and 4-phase multi-cycle) share one stimulus stream.
module tb_id_stage_mc;

    localparam int DW = 32;
    localparam logic [3:0] MC_OP = 4'b0011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0;
    logic [31:0]   instr = '0;
    logic          instr_valid = 1'b0;
    logic [DW-1:0] result_wb = '0;
    logic          wb_en_in = 1'b0;
    logic [3:0]    dest_wb = '0;
    logic [3:0]    sr = '0;
    logic          hazard = 1'b0;
    logic          flush = 1'b0;

    logic          stall_if_o [2];
    logic [3:0]    src1_o [2];
    logic [3:0]    src2_o [2];
    logic          two_src_o [2];
    logic          wb_en_o [2];
    logic          mem_r_en_o [2];
    logic          mem_w_en_o [2];
    logic          b_o [2];
    logic          s_o [2];
    logic [3:0]    exe_cmd_o [2];
    logic [DW-1:0] val_rn_o [2];
    logic [DW-1:0] val_rm_o [2];
    logic          imm_o [2];
    logic [11:0]   shift_o [2];
    logic [23:0]   simm_o [2];
    logic [3:0]    dest_o [2];
    logic          mc_last_o [2];

    id_stage_mc #(.DATA_W(DW), .MC_CYCLES(2), .MC_OPCODE(MC_OP)) u_dut2 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .result_wb(result_wb), .wb_en_in(wb_en_in), .dest_wb(dest_wb), .sr(sr),
        .hazard(hazard), .flush(flush),
        .stall_if(stall_if_o[0]), .src1(src1_o[0]), .src2(src2_o[0]), .two_src(two_src_o[0]),
        .wb_en(wb_en_o[0]), .mem_r_en(mem_r_en_o[0]), .mem_w_en(mem_w_en_o[0]),
        .b(b_o[0]), .s(s_o[0]), .exe_cmd(exe_cmd_o[0]), .val_rn(val_rn_o[0]),
        .val_rm(val_rm_o[0]), .imm(imm_o[0]), .shift_operand(shift_o[0]),
        .signed_imm_24(simm_o[0]), .dest(dest_o[0]), .mc_last(mc_last_o[0])
    );

    id_stage_mc #(.DATA_W(DW), .MC_CYCLES(4), .MC_OPCODE(MC_OP)) u_dut4 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .result_wb(result_wb), .wb_en_in(wb_en_in), .dest_wb(dest_wb), .sr(sr),
        .hazard(hazard), .flush(flush),
        .stall_if(stall_if_o[1]), .src1(src1_o[1]), .src2(src2_o[1]), .two_src(two_src_o[1]),
        .wb_en(wb_en_o[1]), .mem_r_en(mem_r_en_o[1]), .mem_w_en(mem_w_en_o[1]),
        .b(b_o[1]), .s(s_o[1]), .exe_cmd(exe_cmd_o[1]), .val_rn(val_rn_o[1]),
        .val_rm(val_rm_o[1]), .imm(imm_o[1]), .shift_operand(shift_o[1]),
        .signed_imm_24(simm_o[1]), .dest(dest_o[1]), .mc_last(mc_last_o[1])
    );

    typedef struct packed {
        logic          wb_en, mem_r_en, mem_w_en, b, s;
        logic [3:0]    exe_cmd;
        logic [DW-1:0] val_rn, val_rm;
        logic          imm;
        logic [11:0]   shift_operand;
        logic [23:0]   signed_imm_24;
        logic [3:0]    dest;
        logic          mc_last;
    } reg_out_t;

    typedef struct packed {
        logic       stall_if;
        logic [3:0] src1, src2;
        logic       two_src;
    } comb_out_t;

    typedef struct {
        int unsigned cyc;
        int          d;
        logic        chk;
        comb_out_t   c;
        reg_out_t    r;
    } exp_t;

    comb_out_t act_c [2];
    reg_out_t  act_r [2];
    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign act_c[g] = {stall_if_o[g], src1_o[g], src2_o[g], two_src_o[g]};
        assign act_r[g] = {wb_en_o[g], mem_r_en_o[g], mem_w_en_o[g], b_o[g], s_o[g],
                           exe_cmd_o[g], val_rn_o[g], val_rm_o[g], imm_o[g], shift_o[g],
                           simm_o[g], dest_o[g], mc_last_o[g]};
    end

    exp_t comb_q [$];
    exp_t reg_q [$];
    int unsigned cyc = 0;
    int checks = 0;
    int passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // {writes_back, alu_cmd} for each ARM data-processing opcode (0 = unsupported)
    logic [4:0] dp_tab [16] = '{
        5'b1_0110, 5'b1_1000, 5'b1_0100, 5'b0_0000,   // AND EOR SUB RSB
        5'b1_0010, 5'b1_0011, 5'b1_0101, 5'b0_0000,   // ADD ADC SBC RSC
        5'b0_0110, 5'b0_0000, 5'b0_0100, 5'b0_0000,   // TST TEQ CMP CMN
        5'b1_0111, 5'b1_0001, 5'b0_0000, 5'b1_1001    // ORR MOV BIC MVN
    };
    logic [DW-1:0] mregs [16];
    int unsigned   ph_done [2];      // phases of the current multi-cycle op already issued
    logic          exp_stall [2];

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic reg_out_t ctrl_of(input logic [31:0] ins);
        reg_out_t o;
        logic [4:0] t;
        o = '0;
        t = dp_tab[ins[24:21]];
        case (ins[27:26])
            2'b00: begin
                o.s = ins[20];
                if (ins[24:21] == MC_OP) begin
                    o.exe_cmd = 4'b1010;
                    o.wb_en = 1'b1;
                end else begin
                    o.wb_en = t[4];
                    o.exe_cmd = t[3:0];
                end
            end
            2'b01: begin
                o.exe_cmd = 4'b0010;
                o.mem_r_en = ins[20];
                o.wb_en = ins[20];
                o.mem_w_en = !ins[20];
            end
            2'b10: o.b = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    int sc [2];   // stall_if cycles observed inside a directed window

    // One clock of stimulus: drive, predict, push expectations, then sample stall at negedge
    task automatic step(input logic r, input logic [31:0] ins, input logic v,
                        input logic h, input logic f, input logic we,
                        input logic [3:0] wd, input logic [DW-1:0] wdat,
                        input logic [3:0] flags);
        exp_t e;
        logic [3:0] s2;
        logic store, bub, mcop, last;
        int n;
        @(posedge clk);
        #1;
        rst = r; instr = ins; instr_valid = v; hazard = h; flush = f;
        wb_en_in = we; dest_wb = wd; result_wb = wdat; sr = flags;
        store = (ins[27:26] == 2'b01) && !ins[20];
        s2 = store ? ins[15:12] : ins[3:0];
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 2 : 4;
            e.cyc = cyc; e.d = d;
            e.c = '0; e.r = '0;
            last = 1'b0;
            exp_stall[d] = 1'b0;
            if (!r) begin
                e.chk = 1'b0;
                ph_done[d] = 0;
            end else begin
                e.chk = 1'b1;
                bub = h || f || !v || !cond_ok(ins[31:28], flags);
                mcop = v && (ins[27:26] == 2'b00) && (ins[24:21] == MC_OP);
                if (ph_done[d] == 0) begin
                    if (mcop && !bub) begin
                        exp_stall[d] = 1'b1;
                        ph_done[d] = 1;
                    end
                end else if (f) begin
                    ph_done[d] = 0;
                end else if (h) begin
                    exp_stall[d] = 1'b1;
                end else if (ph_done[d] == n - 1) begin
                    last = 1'b1;
                    ph_done[d] = 0;
                end else begin
                    exp_stall[d] = 1'b1;
                    ph_done[d]++;
                end
                e.c = {exp_stall[d], ins[19:16], s2, store || !ins[25]};
                if (!bub) e.r = ctrl_of(ins);
                e.r.mc_last = last && !bub;
                e.r.val_rn = (we && wd == ins[19:16]) ? wdat : mregs[ins[19:16]];
                e.r.val_rm = (we && wd == s2) ? wdat : mregs[s2];
                e.r.imm = ins[25];
                e.r.shift_operand = ins[11:0];
                e.r.signed_imm_24 = ins[23:0];
                e.r.dest = last ? ins[19:16] : ins[15:12];
            end
            comb_q.push_back(e);
            reg_q.push_back(e);
        end
        if (!r) begin
            for (int i = 0; i < 16; i++) mregs[i] = '0;
        end else if (we) begin
            mregs[wd] = wdat;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) if (stall_if_o[d]) sc[d]++;
    endtask

    // Monitor: combinational expectations are due this cycle, registered ones one edge later
    always @(negedge clk) begin
        exp_t m;
        while (comb_q.size() > 0) begin
            m = comb_q.pop_front();
            if (m.chk) begin
                checks++;
                if (act_c[m.d] !== m.c)
                    $display("FAIL comb dut%0d cyc%0d got=%h want=%h", m.d, m.cyc, act_c[m.d], m.c);
                else
                    passed++;
            end
        end
        while (reg_q.size() > 0 && reg_q[0].cyc < cyc) begin
            m = reg_q.pop_front();
            checks++;
            if (act_r[m.d] !== m.r)
                $display("FAIL idex dut%0d cyc%0d got=%h want=%h", m.d, m.cyc, act_r[m.d], m.r);
            else
                passed++;
        end
    end

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) $display("FAIL %s got=%0d want=%0d", name, got, want);
        else passed++;
    endtask

    function automatic logic [31:0] dp(input logic [3:0] c, input logic [3:0] op,
                                       input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [3:0] rm);
        return {c, 2'b00, 1'b0, op, 1'b0, rn, rd, 8'h00, rm};
    endfunction

    localparam logic [3:0] AL = 4'hE;
    logic [31:0] add_r3, add_eq, mc_op, str_r5, cur;
    logic hz, fl;

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        ph_done[0] = 0; ph_done[1] = 0;
        exp_stall[0] = 1'b0; exp_stall[1] = 1'b0;
        add_r3 = dp(AL, 4'b0100, 4'd3, 4'd4, 4'd3);
        add_eq = dp(4'h0, 4'b0100, 4'd6, 4'd7, 4'd8);
        mc_op  = dp(AL, MC_OP, 4'd1, 4'd2, 4'd5);
        str_r5 = {AL, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd5, 12'h004};

        // reset, then write R3 while reading it
        step(0, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        step(0, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, add_r3, 1, 0, 0, 1, 4'd3, 32'h55, 4'h0);
        step(1, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);

        // condition EQ: fail with Z=0, pass with Z=1
        step(1, add_eq, 1, 0, 0, 0, 4'd0, '0, 4'b0000);
        step(1, add_eq, 1, 0, 0, 0, 4'd0, '0, 4'b0100);

        // two-phase op: one stall cycle
        step(0, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        sc[0] = 0; sc[1] = 0;
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        check_int("mc2_stall_cycles", sc[0], 1);
        step(1, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);

        // four-phase op with two hazard cycles at ph=2
        step(0, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        sc[0] = 0; sc[1] = 0;
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 1, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 1, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        check_int("mc4_stall_cycles", sc[1], 5);
        step(1, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);

        // flush at ph=1 drops stall the same cycle
        step(0, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        sc[0] = 0; sc[1] = 0;
        step(1, mc_op, 1, 0, 0, 0, 4'd0, '0, 4'h0);
        step(1, mc_op, 1, 0, 1, 0, 4'd0, '0, 4'h0);
        check_int("flush_stall_cycles", sc[1], 1);
        step(1, add_r3, 1, 0, 0, 0, 4'd0, '0, 4'h0);

        // store reads Rd through src2
        step(1, '0, 0, 0, 0, 1, 4'd5, 32'h1234, 4'h0);
        step(1, str_r5, 1, 0, 0, 0, 4'd0, '0, 4'h0);

        // randomized traffic; IF/ID holds while stalled or hazarded
        cur = mc_op;
        for (int k = 0; k < 400; k++) begin
            if (!((exp_stall[0] || exp_stall[1] || hazard) && !flush)) begin
                cur = $urandom;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: cur[27:26] = 2'b00;
                    6, 7:             cur[27:26] = 2'b01;
                    8:                cur[27:26] = 2'b10;
                    default: ;
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    cur[27:26] = 2'b00;
                    cur[24:21] = MC_OP;
                end
                if ($urandom_range(0, 1) == 1) cur[31:28] = AL;
            end
            hz = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 99) != 0), cur, ($urandom_range(0, 9) != 0), hz, fl,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)));
        end

        step(1, '0, 0, 0, 0, 0, 4'd0, '0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check_int("scoreboard_drained", reg_q.size() + comb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
